// File: rtl/ula_arb_pkg.sv
// Shared constants for the two-requester ULA arbiter: op codes, FSM encoding, datapath width.
package ula_arb_pkg;

  localparam int ULA_WIDTH = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/ula_arbiter_ula.sv
// 4-bit behavioural ALU; purely combinational, results truncated mod 16.
// Shifts by 4 or more produce 0.
module ULA
  import ula_arb_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] y_o
);

  always_comb begin
    y_o = 4'd0;
    case (op_i)
      OP_ADD: y_o = a_i + b_i;
      OP_SUB: y_o = a_i - b_i;
      OP_SHL: y_o = (b_i >= 4'd4) ? 4'd0 : (a_i << b_i[1:0]);
      OP_SHR: y_o = (b_i >= 4'd4) ? 4'd0 : (a_i >> b_i[1:0]);
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_NOT: y_o = ~a_i;
      default: y_o = 4'd0;
    endcase
  end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin share of one ULA between two requesters: 2 cycles handshake-to-response, 3 cycles/op;
// both req_ready drop while busy and the result is held until its owner accepts it. Flags: ULA_ARB_FLAGS_EN.
module ula_arbiter
  import ula_arb_pkg::*;
#(
  parameter int WIDTH   = ULA_WIDTH,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
`ifdef ULA_ARB_FLAGS_EN
  output logic             rsp0_zero,
  output logic             rsp0_carry,
  output logic             rsp1_zero,
  output logic             rsp1_carry,
`endif
  output logic             busy
);

  if (WIDTH != ULA_WIDTH) begin : g_width_check
    $error("ula_arbiter: WIDTH must be 4 to match ULA");
  end

  localparam logic RR_PRIO = (RR_INIT != 0);

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] ula_y;

  logic idle;
  logic grant0, grant1;
  logic hs0, hs1;

  ULA u_ula (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (ula_y)
  );

  assign idle   = (state_q == ST_IDLE);
  assign grant0 = req0_valid && (!req1_valid || !prio_q);
  assign grant1 = req1_valid && (!req0_valid ||  prio_q);

  // Ready is held low while reset is asserted so no request is lost into a reset edge.
  assign req0_ready = idle && grant0 && !rst;
  assign req1_ready = idle && grant1 && !rst;
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;

  assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign busy       = !idle;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (hs0 || hs1) begin
          state_d = ST_EXEC;
          owner_d = hs1;
          prio_d  = !hs1;
          op_d    = hs1 ? req1_op : req0_op;
          a_d     = hs1 ? req1_a  : req0_a;
          b_d     = hs1 ? req1_b  : req0_b;
        end
      end
      ST_EXEC: begin
        res_d   = ula_y;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= RR_PRIO;
      owner_q <= 1'b0;
      op_q    <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

`ifdef ULA_ARB_FLAGS_EN
  logic [WIDTH:0] sum_w, diff_w;
  logic           zero_q, zero_d;
  logic           carry_q, carry_d;

  // Extra top bit of the 5-bit add/sub is carry-out for add and borrow for sub.
  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    if (state_q == ST_EXEC) begin
      zero_d  = (ula_y == '0);
      carry_d = (op_q == OP_ADD) ? sum_w[WIDTH] :
                (op_q == OP_SUB) ? diff_w[WIDTH] : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign rsp0_zero  = rsp0_valid && zero_q;
  assign rsp0_carry = rsp0_valid && carry_q;
  assign rsp1_zero  = rsp1_valid && zero_q;
  assign rsp1_carry = rsp1_valid && carry_q;
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: directed vectors, random ops against an arithmetic model,
// round-robin fairness with response backpressure, and reset during execution.
module tb_ula_arbiter;

  localparam int RR = 0;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready, rsp1_ready;
  logic [3:0] rsp0_data, rsp1_data;
  logic       busy;
`ifdef ULA_ARB_FLAGS_EN
  logic       rsp0_zero, rsp0_carry, rsp1_zero, rsp1_carry;
`endif

  logic [1:0] req_rdy_w;
  logic [1:0] rsp_vld_w;
  assign req_rdy_w = {req1_ready, req0_ready};
  assign rsp_vld_w = {rsp1_valid, rsp0_valid};

  int checks   = 0;
  int failures = 0;
  int mprio    = RR;

  ula_arbiter #(.WIDTH(4), .RR_INIT(RR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
`ifdef ULA_ARB_FLAGS_EN
    .rsp0_zero  (rsp0_zero),
    .rsp0_carry (rsp0_carry),
    .rsp1_zero  (rsp1_zero),
    .rsp1_carry (rsp1_carry),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = a;
    ib = b;
    case (op)
      3'd0: r = ia + ib;
      3'd1: r = ia - ib + 16;
      3'd2: r = (ib >= 4) ? 0 : ia * (1 << ib);
      3'd3: r = (ib >= 4) ? 0 : ia / (1 << ib);
      3'd4: r = ia & ib;
      3'd5: r = ia | ib;
      3'd6: r = ia ^ ib;
      default: r = 15 - ia;
    endcase
    return 4'(r % 16);
  endfunction

  function automatic logic ref_carry(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib;
    ia = a;
    ib = b;
    if (op == 3'd0) return (ia + ib) > 15;
    if (op == 3'd1) return ib > ia;
    return 1'b0;
  endfunction

  task automatic drive_req(input int n, input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic drive_rsp_ready(input int n, input logic v);
    if (n == 0) rsp0_ready = v;
    else        rsp1_ready = v;
  endtask

  task automatic run_single(input int n, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int         lat;
    logic [1:0] own;
    logic [3:0] exp_d, got_d;
    own   = (n == 0) ? 2'b01 : 2'b10;
    exp_d = ref_alu(op, a, b);
    @(negedge clk);
    drive_req(n, 1'b1, op, a, b);
    drive_rsp_ready(1 - n, 1'($urandom % 2));
    #1;
    checks++;
    if (req_rdy_w !== own) begin
      failures++;
      $display("FAIL single_grant: req_ready=%b expected %b", req_rdy_w, own);
    end
    @(posedge clk);
    mprio = 1 - n;
    @(negedge clk);
    drive_req(n, 1'b0, op, a, b);
    drive_rsp_ready(n, 1'($urandom % 2));
    #1;
    checks++;
    if (busy !== 1'b1 || rsp_vld_w !== 2'b00 || req_rdy_w !== 2'b00) begin
      failures++;
      $display("FAIL exec_state: busy=%b rsp_valid=%b req_ready=%b expected 1 00 00", busy, rsp_vld_w, req_rdy_w);
    end
    lat = 1;
    while (lat < 8) begin
      @(negedge clk);
      drive_rsp_ready(n, 1'b0);
      #1;
      lat++;
      if (rsp_vld_w[n] === 1'b1) break;
    end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL rsp_latency: got %0d cycles expected 2", lat);
    end
    checks++;
    if (rsp_vld_w !== own) begin
      failures++;
      $display("FAIL rsp_owner: rsp_valid=%b expected %b", rsp_vld_w, own);
    end
    got_d = (n == 0) ? rsp0_data : rsp1_data;
    checks++;
    if (got_d !== exp_d) begin
      failures++;
      $display("FAIL rsp_data: op=%0d a=%0d b=%0d got %0d expected %0d", op, a, b, got_d, exp_d);
    end
`ifdef ULA_ARB_FLAGS_EN
    checks++;
    if (((n == 0) ? rsp0_zero : rsp1_zero) !== (exp_d == 4'd0)) begin
      failures++;
      $display("FAIL rsp_zero: op=%0d a=%0d b=%0d got %b expected %b", op, a, b,
               (n == 0) ? rsp0_zero : rsp1_zero, (exp_d == 4'd0));
    end
    checks++;
    if (((n == 0) ? rsp0_carry : rsp1_carry) !== ref_carry(op, a, b)) begin
      failures++;
      $display("FAIL rsp_carry: op=%0d a=%0d b=%0d got %b expected %b", op, a, b,
               (n == 0) ? rsp0_carry : rsp1_carry, ref_carry(op, a, b));
    end
`endif
    drive_rsp_ready(n, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_rsp_ready(0, 1'b0);
    drive_rsp_ready(1, 1'b0);
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_vld_w !== 2'b00) begin
      failures++;
      $display("FAIL rsp_release: busy=%b rsp_valid=%b expected 0 00", busy, rsp_vld_w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
    drive_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_rdy_w !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b expected 00", req_rdy_w); end
    checks++;
    if (rsp_vld_w !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_vld_w); end
    checks++;
    if (rsp0_data !== 4'd0 || rsp1_data !== 4'd0) begin
      failures++;
      $display("FAIL reset_rsp_data: got %0d/%0d expected 0/0", rsp0_data, rsp1_data);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef ULA_ARB_FLAGS_EN
    checks++;
    if ({rsp0_zero, rsp0_carry, rsp1_zero, rsp1_carry} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000", {rsp0_zero, rsp0_carry, rsp1_zero, rsp1_carry});
    end
`endif
    mprio = RR;
  endtask

  task automatic test_directed();
    run_single(0, 3'b000, 4'd5,  4'd3);
    run_single(1, 3'b001, 4'd3,  4'd5);
    run_single(0, 3'b010, 4'd3,  4'd2);
    run_single(1, 3'b011, 4'd12, 4'd5);
    run_single(0, 3'b111, 4'd5,  4'd0);
    run_single(1, 3'b000, 4'd8,  4'd8);
    run_single(0, 3'b010, 4'd15, 4'd4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_single($urandom % 2, 3'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  task automatic test_arbitration();
    int         g, wait_c, lat, hold;
    logic [1:0] own;
    logic [3:0] exp_d, held, got_d;
    @(negedge clk);
    rst = 1'b1;
    drive_req(0, 1'b1, 3'b000, 4'd1, 4'd1);
    drive_req(1, 1'b1, 3'b100, 4'd6, 4'd3);
    #1;
    checks++;
    if (req_rdy_w !== 2'b00) begin failures++; $display("FAIL arb_ready_in_reset: got %b expected 00", req_rdy_w); end
    @(negedge clk);
    rst   = 1'b0;
    mprio = RR;
    for (int k = 0; k < 6; k++) begin
      #1;
      wait_c = 0;
      while (req_rdy_w === 2'b00 && wait_c < 8) begin
        @(negedge clk);
        #1;
        wait_c++;
      end
      g   = mprio;
      own = (g == 0) ? 2'b01 : 2'b10;
      checks++;
      if (req_rdy_w !== own) begin
        failures++;
        $display("FAIL grant_order: txn %0d req_ready=%b expected %b", k, req_rdy_w, own);
      end
      checks++;
      if (wait_c != 0) begin
        failures++;
        $display("FAIL regrant_gap: txn %0d waited %0d cycles expected 0", k, wait_c);
      end
      @(posedge clk);
      mprio = 1 - g;
      exp_d = (g == 0) ? ref_alu(3'b000, 4'd1, 4'd1) : ref_alu(3'b100, 4'd6, 4'd3);
      lat   = 0;
      do begin
        @(negedge clk);
        #1;
        lat++;
        checks++;
        if (req_rdy_w !== 2'b00) begin
          failures++;
          $display("FAIL stall_ready: txn %0d req_ready=%b expected 00", k, req_rdy_w);
        end
      end while (rsp_vld_w[g] !== 1'b1 && lat < 8);
      checks++;
      if (lat != 2) begin failures++; $display("FAIL arb_latency: txn %0d got %0d expected 2", k, lat); end
      held = (g == 0) ? rsp0_data : rsp1_data;
      hold = (k == 0) ? 4 : int'($urandom % 3);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        #1;
        got_d = (g == 0) ? rsp0_data : rsp1_data;
        checks++;
        if (rsp_vld_w !== own || got_d !== held || req_rdy_w !== 2'b00) begin
          failures++;
          $display("FAIL hold_stable: txn %0d rsp_valid=%b data=%0d req_ready=%b expected %b %0d 00",
                   k, rsp_vld_w, got_d, req_rdy_w, own, held);
        end
      end
      got_d = (g == 0) ? rsp0_data : rsp1_data;
      checks++;
      if (got_d !== exp_d) begin
        failures++;
        $display("FAIL arb_data: txn %0d requester %0d got %0d expected %0d", k, g, got_d, exp_d);
      end
      drive_rsp_ready(g, 1'b1);
      if (k == 5) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      drive_rsp_ready(g, 1'b0);
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL arb_final_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    drive_req(1, 1'b1, 3'b001, 4'd9, 4'd2);
    @(posedge clk);
    @(negedge clk);
    drive_req(1, 1'b0, 3'b001, 4'd9, 4'd2);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midrst_in_exec: busy=%b expected 1", busy); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_vld_w !== 2'b00 || req_rdy_w !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs: rsp_valid=%b req_ready=%b busy=%b expected 00 00 0", rsp_vld_w, req_rdy_w, busy);
    end
    mprio = RR;
    seen  = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (rsp_vld_w !== 2'b00) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midrst_no_response: got %0d valid cycles expected 0", seen); end
    run_single(1, 3'b000, 4'd7, 4'd4);
    run_single(0, 3'b110, 4'd10, 4'd6);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_arbitration();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
